// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// MEM_ARB_EXT_PORT_EN adds the external (loader/debug) requester as a third port.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

`ifdef MEM_ARB_EXT_PORT_EN
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        ID_IF  = 2'd0,
        ID_DAT = 2'd1,
        ID_EXT = 2'd2
    } req_id_t;

    // Pointer starts on the highest id so IF is searched first out of reset
    localparam req_id_t LAST_RST = ID_EXT;
`else
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    typedef enum logic [0:0] {
        ID_IF  = 1'b0,
        ID_DAT = 1'b1
    } req_id_t;

    // Pointer starts on the highest id so IF is searched first out of reset
    localparam req_id_t LAST_RST = ID_DAT;
`endif

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: the search starts one past `last`
// and wraps; the first asserted request wins.
module arb_rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] id
);

    logic found;

    // Walk candidates in rotating order and latch onto the first requester
    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((int'(last) + off) % N))) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    id     = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch, data and (optionally) an
// external requester, and routes read data back with a fixed-latency tag pipe.
// MEM_ARB_EXT_PORT_EN enables the external requester ports.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_dat_req,
    input  logic [ADDR_W-1:0] i_dat_addr,
    input  logic              i_dat_wr,
    input  logic [DATA_W-1:0] i_dat_wrdata,
`ifdef MEM_ARB_EXT_PORT_EN
    input  logic              i_ext_req,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic              i_ext_wr,
    input  logic [DATA_W-1:0] i_ext_wrdata,
    output logic              o_ext_gnt,
    output logic              o_ext_rvalid,
`endif
    output logic              o_if_gnt,
    output logic              o_dat_gnt,
    output logic              o_if_rvalid,
    output logic              o_dat_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic [DATA_W-1:0] i_mem_rddata
);

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [ID_W-1:0]    pick_id;
    logic               any_gnt;
    logic               win_wr;
    req_id_t            win_id;
    req_id_t            last;
    tag_t               tag_q [READ_LAT];
    tag_t               tag_out;

    // Requests are masked while reset is low so no grant or strobe escapes
`ifdef MEM_ARB_EXT_PORT_EN
    assign req_vec = reset ? {i_ext_req, i_dat_req, i_if_req} : '0;
`else
    assign req_vec = reset ? {i_dat_req, i_if_req} : '0;
`endif

    arb_rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_pick (
        .req  (req_vec),
        .last (last),
        .gnt  (gnt_vec),
        .id   (pick_id)
    );

    assign win_id    = req_id_t'(pick_id);
    assign any_gnt   = |gnt_vec;
    assign o_if_gnt  = gnt_vec[0];
    assign o_dat_gnt = gnt_vec[1];
`ifdef MEM_ARB_EXT_PORT_EN
    assign o_ext_gnt = gnt_vec[2];
`endif

    // Steer the winner's payload onto the memory port, zero when idle
    always_comb begin
        o_mem_addr   = '0;
        o_mem_wrdata = '0;
        win_wr       = 1'b0;
        if (any_gnt) begin
            case (win_id)
                ID_IF: begin
                    o_mem_addr = i_if_addr;
                end
                ID_DAT: begin
                    o_mem_addr   = i_dat_addr;
                    o_mem_wrdata = i_dat_wrdata;
                    win_wr       = i_dat_wr;
                end
`ifdef MEM_ARB_EXT_PORT_EN
                ID_EXT: begin
                    o_mem_addr   = i_ext_addr;
                    o_mem_wrdata = i_ext_wrdata;
                    win_wr       = i_ext_wr;
                end
`endif
                default: begin
                    o_mem_addr = '0;
                end
            endcase
        end
    end

    assign o_mem_rd = any_gnt & ~win_wr;
    assign o_mem_wr = any_gnt & win_wr;

    // Round-robin pointer only advances on cycles that actually grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            last <= LAST_RST;
        end else if (any_gnt) begin
            last <= win_id;
        end
    end

    // Tag pipe mirrors the memory latency so returning data finds its owner
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                tag_q[i] <= tag_t'{valid: 1'b0, id: ID_IF};
            end
        end else begin
            tag_q[0] <= tag_t'{valid: o_mem_rd, id: win_id};
            for (int i = 1; i < READ_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out      = tag_q[READ_LAT-1];
    assign o_if_rvalid  = tag_out.valid && (tag_out.id == ID_IF);
    assign o_dat_rvalid = tag_out.valid && (tag_out.id == ID_DAT);
`ifdef MEM_ARB_EXT_PORT_EN
    assign o_ext_rvalid = tag_out.valid && (tag_out.id == ID_EXT);
`endif
    assign o_rdata      = i_mem_rddata;

endmodule
